fetch_unit: RTL

Instruction fetch stage directly upstream of decode/immediate generation. Maintains the PC and issues word requests to instruction memory with at most one request outstanding. Buffers returned instructions in a 2-entry FIFO and presents {pc, instruction, opcode} to decode with a valid/ready handshake. Handles redirects from branch/jump resolution by flushing buffered and in-flight fetches.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding imem requests,
// a 2-entry instruction buffer toward decode, and redirect flushing.
module fetch_unit #(
  parameter int                    INST_WIDTH = 32,
  parameter int                    OPCODE     = 7,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [OPCODE-1:0]     opcode_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] fifo_pc   [2];
  logic [INST_WIDTH-1:0] fifo_inst [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            count_q;
  logic                  fire, push, pop;
  logic [ADDR_WIDTH-1:0] redirect_target;

  assign redirect_target = redirect_pc_i & ~ADDR_WIDTH'(3);

  // A new request is only offered when the buffer can absorb its response.
  assign imem_req_o   = (state_q == REQ) && (count_q != 2'd2);
  assign imem_addr_o  = pc_q;
  assign fire         = imem_req_o && imem_gnt_i;

  assign inst_valid_o = (count_q != 2'd0);
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_o       = inst_valid_o ? fifo_inst[rd_ptr_q] : '0;
  assign pc_o         = inst_valid_o ? fifo_pc[rd_ptr_q]   : '0;
  assign opcode_o     = inst_o[OPCODE-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    push    = 1'b0;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (fire) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_d = REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            push = 1'b1;
            pc_d = pc_q + ADDR_WIDTH'(4);
          end
        end
      end
      default: state_d = BOOT;
    endcase
    // Redirect wins over everything; only a still-unanswered request needs dropping.
    if (redirect_i) begin
      pc_d = redirect_target;
      push = 1'b0;
      if ((state_q == REQ && fire) || (state_q == WAIT && !imem_rvalid_i))
        drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (redirect_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc[wr_ptr_q]   <= pc_q;
      fifo_inst[wr_ptr_q] <= imem_rdata_i;
    end
  end

endmodule
